// File: rtl/tpg_pkg.sv
// Shared constants and helpers for the 3-bit exhaustive test pattern generator.
package tpg_pkg;

  // Width of the generated pattern {a, b, cin}.
  localparam int TPG_W = 3;

  // Reset value of the LFSR state. It must be non-zero.
  localparam logic [TPG_W-1:0] DEFAULT_SEED = 3'b001;

  // Number of distinct patterns in one exhaustive pass.
  localparam int NUM_PATTERNS = 8;

  // Feedback taps for x^3 + x^2 + 1, applied to state bits [2] and [1].
  localparam logic [TPG_W-1:0] TAP_MASK = 3'b110;

  // Counter value that is present while the last pattern of a pass is shown.
  localparam logic [TPG_W-1:0] LAST_COUNT = 3'(NUM_PATTERNS - 1);

  // XOR of the tapped state bits, which gives the linear part of the feedback.
  function automatic logic tap_parity(input logic [TPG_W-1:0] q);
    return ^(q & TAP_MASK);
  endfunction

  // Zero-insertion term. It is high when the low bits are 00. This splices
  // the all-zero state into the maximal-length cycle, so the LFSR cannot
  // lock up in 000.
  function automatic logic zero_insert(input logic [TPG_W-1:0] q);
    return (q[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/lfsr3_next.sv
// Combinational next-state function for the 3-bit de Bruijn LFSR.
// Starting from 001 it gives the sequence 001,010,101,011,111,110,100,000.
import tpg_pkg::*;

module lfsr3_next (
  input  logic [TPG_W-1:0] q_i,
  output logic [TPG_W-1:0] q_next_o
);

  logic fb_s;

  // Feedback is the tap parity plus the zero-insertion term. The state shifts left.
  always_comb begin
    fb_s     = tap_parity(q_i) ^ zero_insert(q_i);
    q_next_o = {q_i[1:0], fb_s};
  end

endmodule

// File: rtl/tpg_3bit_lfsr.sv
// 3-bit BIST test pattern generator for a 1-bit full adder.
// data_out shows the LFSR state directly: [2]=a, [1]=b, [0]=cin.
// complete is registered. It rises on the edge that loads the 8th pattern (000).
import tpg_pkg::*;

module tpg_3bit_lfsr #(
  parameter logic [2:0] SEED     = DEFAULT_SEED,
  parameter bit         FREE_RUN = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  output logic [2:0] data_out,
  output logic       complete
);

  logic [TPG_W-1:0] state_q;
  logic [TPG_W-1:0] state_d;
  logic [TPG_W-1:0] cnt_q;
  logic [TPG_W-1:0] cnt_d;
  logic             complete_q;
  logic             complete_d;
  logic [TPG_W-1:0] lfsr_next_s;
  logic             advance_s;

  lfsr3_next u_lfsr3_next (
    .q_i      (state_q),
    .q_next_o (lfsr_next_s)
  );

  // In one-shot mode the generator stops on the last pattern. In free-run mode it always advances.
  always_comb begin
    if (FREE_RUN) begin
      advance_s = 1'b1;
    end else begin
      advance_s = ~complete_q;
    end
  end

  // Next-state logic for the pattern, the counter and the completion flag.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    complete_d = complete_q;
    if (advance_s) begin
      state_d    = lfsr_next_s;
      cnt_d      = cnt_q + 3'd1;
      complete_d = (cnt_d == LAST_COUNT);
    end else begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      complete_d = complete_q;
    end
  end

  // State, counter and flag registers. Reset is asynchronous and active-high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= SEED;
      cnt_q      <= 3'd0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      complete_q <= complete_d;
    end
  end

  assign data_out = state_q;
  assign complete = complete_q;

endmodule

// File: tb/tb_tpg_3bit_lfsr.sv
// Directed testbench for tpg_3bit_lfsr. One instance runs in one-shot mode and one in free-run mode.
module tb_tpg_3bit_lfsr;

  logic       clock;
  logic       rst_os;
  logic       rst_fr;
  logic [2:0] data_os;
  logic       complete_os;
  logic [2:0] data_fr;
  logic       complete_fr;

  int tests_run;
  int tests_failed;

  logic [2:0] exp_seq [8];

  tpg_3bit_lfsr #(.SEED(3'b001), .FREE_RUN(1'b0)) u_dut_os (
    .clock    (clock),
    .reset    (rst_os),
    .data_out (data_os),
    .complete (complete_os)
  );

  tpg_3bit_lfsr #(.SEED(3'b001), .FREE_RUN(1'b1)) u_dut_fr (
    .clock    (clock),
    .reset    (rst_fr),
    .data_out (data_fr),
    .complete (complete_fr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse reset on the one-shot instance across two edges, then release it on a falling edge.
  task automatic reset_os();
    @(negedge clock);
    rst_os = 1'b1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    rst_os = 1'b0;
  endtask

  task automatic test_reset();
    reset_os();
    tests_run++;
    if (data_os !== 3'b001 || complete_os !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: data=%b complete=%b required data=001 complete=0", data_os, complete_os);
    end
    for (int i = 1; i <= 7; i++) begin
      @(posedge clock); #1;
      tests_run++;
      if (data_os !== exp_seq[i] || complete_os !== (i == 7)) begin
        tests_failed++;
        $display("FAIL seq_edge%0d: data=%b complete=%b required data=%b complete=%b",
                 i, data_os, complete_os, exp_seq[i], (i == 7));
      end
    end
  endtask

  task automatic test_coverage_hold();
    logic [7:0] seen;
    reset_os();
    seen = 8'h00;
    seen[data_os] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clock); #1;
      seen[data_os] = 1'b1;
    end
    tests_run++;
    if (seen !== 8'hFF) begin
      tests_failed++;
      $display("FAIL coverage: seen=%b required 11111111", seen);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      tests_run++;
      if (data_os !== 3'b000 || complete_os !== 1'b1) begin
        tests_failed++;
        $display("FAIL hold_edge%0d: data=%b complete=%b required data=000 complete=1", i, data_os, complete_os);
      end
    end
  endtask

  task automatic test_async_reset_mid();
    reset_os();
    for (int i = 0; i < 3; i++) @(posedge clock);
    #1;
    tests_run++;
    if (data_os !== 3'b011) begin
      tests_failed++;
      $display("FAIL mid_pre: data=%b required 011", data_os);
    end
    #2 rst_os = 1'b1;
    #1;
    tests_run++;
    if (data_os !== 3'b001 || complete_os !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_async: data=%b complete=%b required data=001 complete=0", data_os, complete_os);
    end
    @(negedge clock);
    rst_os = 1'b0;
    @(posedge clock); #1;
    tests_run++;
    if (data_os !== 3'b010) begin
      tests_failed++;
      $display("FAIL mid_restart: data=%b required 010", data_os);
    end
  endtask

  task automatic test_reset_after_complete();
    reset_os();
    for (int i = 0; i < 9; i++) @(posedge clock);
    #3;
    tests_run++;
    if (complete_os !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_complete: complete=%b required 1", complete_os);
    end
    rst_os = 1'b1;
    #1;
    tests_run++;
    if (data_os !== 3'b001 || complete_os !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_complete_async: data=%b complete=%b required data=001 complete=0", data_os, complete_os);
    end
    @(negedge clock);
    rst_os = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clock); #1;
      tests_run++;
      if (data_os !== exp_seq[i] || complete_os !== (i == 7)) begin
        tests_failed++;
        $display("FAIL repass_edge%0d: data=%b complete=%b required data=%b complete=%b",
                 i, data_os, complete_os, exp_seq[i], (i == 7));
      end
    end
  endtask

  task automatic test_free_run();
    @(negedge clock);
    rst_fr = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rst_fr = 1'b0;
    tests_run++;
    if (data_fr !== 3'b001 || complete_fr !== 1'b0) begin
      tests_failed++;
      $display("FAIL fr_reset: data=%b complete=%b required data=001 complete=0", data_fr, complete_fr);
    end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      tests_run++;
      if (data_fr !== exp_seq[i % 8] || complete_fr !== ((i % 8) == 7)) begin
        tests_failed++;
        $display("FAIL fr_edge%0d: data=%b complete=%b required data=%b complete=%b",
                 i, data_fr, complete_fr, exp_seq[i % 8], ((i % 8) == 7));
      end
    end
  endtask

  task automatic test_reset_hold();
    @(negedge clock);
    rst_os = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      tests_run++;
      if (data_os !== 3'b001 || complete_os !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_reset%0d: data=%b complete=%b required data=001 complete=0", i, data_os, complete_os);
      end
    end
    @(negedge clock);
    rst_os = 1'b0;
    @(posedge clock); #1;
    tests_run++;
    if (data_os !== 3'b010) begin
      tests_failed++;
      $display("FAIL hold_release: data=%b required 010", data_os);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_seq[0] = 3'b001;
    exp_seq[1] = 3'b010;
    exp_seq[2] = 3'b101;
    exp_seq[3] = 3'b011;
    exp_seq[4] = 3'b111;
    exp_seq[5] = 3'b110;
    exp_seq[6] = 3'b100;
    exp_seq[7] = 3'b000;
    rst_os = 1'b1;
    rst_fr = 1'b1;
    repeat (2) @(posedge clock);

    test_reset();
    test_coverage_hold();
    test_async_reset_mid();
    test_reset_after_complete();
    test_free_run();
    test_reset_hold();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tpg_3bit_lfsr.md
Name: tpg_3bit_lfsr

Overview:
3-bit test pattern generator (TPG) for the built-in self-test (BIST) of a 1-bit full adder. A modified (de Bruijn) LFSR steps through all 8 input combinations {a,b,cin}, including 000, one per clock. It flags `complete` when the exhaustive set has been applied. It sits ahead of the full-adder CUT and feeds the BIST response analyser/controller.

Parameters:
- SEED, default 3'b001, LFSR state loaded on reset; must be non-zero.
- FREE_RUN, default 0. When 0, the generator halts on the last pattern. When 1, it cycles indefinitely.

Ports:
- clock  input  1  Rising-edge system clock.
- reset  input  1  Asynchronous, active-high reset.
- data_out  output  3  Current test pattern, equal to the LFSR state. data_out[2]=a, [1]=b, [0]=cin.
- complete  output  1  High once all 8 patterns have been presented.

Behaviour:
- Reset state (asynchronous on reset=1, held while reset=1):
  - state=SEED, so data_out=001.
  - pattern counter=0.
  - complete=0.
- Next-state function:
  - fb = q[2] ^ q[1] ^ (q[1:0]==2'b00). This is polynomial x^3+x^2+1 with zero-insertion.
  - q_next = {q[1:0], fb}.
- Sequence from SEED=001 over 8 states:
  - 001 → 010 → 101 → 011 → 111 → 110 → 100 → 000 → 001 …
- Pattern counter:
  - 3-bit, increments on every advance.
  - It is 7 exactly when the 8th pattern (000) is on data_out.
- complete:
  - Registered, and updated on the same edge that loads the 8th pattern.
  - After release of reset, edges 1..7 present 010, 101, 011, 111, 110, 100, 000.
  - complete rises on edge 7, together with data_out=000.
- FREE_RUN=0:
  - After complete=1, state and counter freeze; data_out holds 000.
  - complete is sticky until reset.
- FREE_RUN=1:
  - LFSR keeps advancing and the counter wraps 7→0.
  - complete=1 only during cycles where counter==7 (one cycle in every 8).
  - Edge 8 returns data_out=001 and complete=0.
- Reset mid-sequence: asynchronously returns to 001, counter 0, complete 0. Sequencing resumes on the first rising edge after deassertion.
- Reset held for many cycles: outputs stay at reset values; no advance.
- All-zero lock-up is impossible: the zero-insertion term exits 000 to 001.
- No combinational path from inputs to outputs other than the asynchronous reset.

Decomposition:
- Shared package `tpg_pkg` holds:
  - TPG_W=3.
  - DEFAULT_SEED=3'b001.
  - NUM_PATTERNS=8.
  - TAP mask 3'b110.
- One natural sub-module: `lfsr3_next`, purely combinational. It computes q_next from q, including the zero-insertion term.
- The top level holds the state register, pattern counter and complete logic.

Test Plan:
- Reset while clocking, then deassert → data_out=001, complete=0. Next 7 edges give 010,101,011,111,110,100,000, with complete=1 exactly on the 7th edge.
- Coverage check, FREE_RUN=0 → the 8 values seen on data_out are all distinct and cover 000..111. After complete, 10 further edges keep data_out=000 and complete=1.
- Assert reset asynchronously mid-cycle at pattern 011 → data_out=001 and complete=0 immediately, without waiting for a clock edge. Sequence restarts 010… after deassertion.
- Assert reset after complete=1 → complete drops to 0 asynchronously and data_out=001. A full 8-pattern pass repeats.
- FREE_RUN=1, 20 edges after reset → sequence repeats with period 8. complete is high only while data_out=000 (edges 7 and 15). Edge 8 gives 001 with complete=0.
- Hold reset=1 across 5 clock edges → data_out stays 001 and complete stays 0 throughout.
